// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: parametrised, pipelined carry-lookahead adder/subtractor.
// The operand width is split into STAGES segments, and each pipeline level adds one segment.
// Each segment uses two levels of lookahead: full lookahead inside each 4-bit group, then
// lookahead across the groups of the segment. The carry out of a segment is registered and
// passed to the next level. Upper operand bits travel forward through skew registers, and
// completed lower result bits travel forward through deskew registers, so that every bit of
// a result leaves the pipeline in the same cycle.
// Optional feature: define CLA_FLAGS_EN to add the registered zero and negative outputs.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef CLA_FLAGS_EN
    output logic             zero,
    output logic             negative,
`endif
    output logic             overflow
);

    localparam int unsigned SEG = WIDTH / STAGES;
    localparam int unsigned NG  = SEG / GROUP;

    // Reject illegal configurations at elaboration time.
    if (GROUP != 4) begin : g_bad_group
        $error("pipelined_cla_adder: GROUP must be 4");
    end
    if ((STAGES < 1) || (STAGES > 8)) begin : g_bad_stages
        $error("pipelined_cla_adder: STAGES must be in 1..8");
    end
    if ((WIDTH % (GROUP * STAGES)) != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES");
    end

    // Bit carries inside one 4-bit group. Each carry is a flat lookahead equation.
    function automatic logic [3:0] group_carries(input logic [3:0] p, input logic [3:0] g,
                                                 input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Group propagate/generate, returned as {P, G}.
    function automatic logic [1:0] group_pg(input logic [3:0] p, input logic [3:0] g);
        logic gp;
        logic gg;
        gp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gp, gg};
    endfunction

    // One segment add, returned as {carry_out, sum}.
    // Every group carry is a sum of products over the group P/G terms (no ripple chain).
    function automatic logic [SEG:0] cla_segment(input logic [SEG-1:0] x,
                                                 input logic [SEG-1:0] y,
                                                 input logic           ci);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] c;
        logic [NG-1:0]  gp;
        logic [NG-1:0]  gg;
        logic [NG:0]    gc;
        logic           term;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < NG; j++) begin
            {gp[j], gg[j]} = group_pg(p[j*GROUP +: GROUP], g[j*GROUP +: GROUP]);
        end
        for (int j = 0; j <= NG; j++) begin
            term = ci;
            for (int i = 0; i < j; i++) begin
                term = term & gp[i];
            end
            gc[j] = term;
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int m = i + 1; m < j; m++) begin
                    term = term & gp[m];
                end
                gc[j] = gc[j] | term;
            end
        end
        for (int j = 0; j < NG; j++) begin
            c[j*GROUP +: GROUP] = group_carries(p[j*GROUP +: GROUP], g[j*GROUP +: GROUP], gc[j]);
        end
        return {gc[NG], p ^ c};
    endfunction

    logic             advance;
    logic             carry0;
    logic [WIDTH-1:0] b_eff;

    // The whole pipeline moves in lockstep. A full output register that is not accepted
    // freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign carry0   = sub | c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]       seg_a;
        logic [SEG-1:0]       seg_b;
        logic [SEG-1:0]       seg_sum;
        logic                 seg_cin;
        logic                 seg_cout;
        logic                 up_valid;
        logic                 valid_d;
        logic                 valid_q;
        logic                 carry_d;
        logic                 carry_q;
        logic [(k+1)*SEG-1:0] res_new;
        logic [(k+1)*SEG-1:0] res_d;
        logic [(k+1)*SEG-1:0] res_q;

        // Level 0 takes its segment straight from the ports. Later levels take theirs from
        // the previous level's skew and carry registers.
        if (k == 0) begin : g_src
            assign seg_a    = a[SEG-1:0];
            assign seg_b    = b_eff[SEG-1:0];
            assign seg_cin  = carry0;
            assign up_valid = in_valid;
            assign res_new  = seg_sum;
        end else begin : g_src
            assign seg_a    = g_stage[k-1].g_skew.a_q[SEG-1:0];
            assign seg_b    = g_stage[k-1].g_skew.b_q[SEG-1:0];
            assign seg_cin  = g_stage[k-1].carry_q;
            assign up_valid = g_stage[k-1].valid_q;
            assign res_new  = {seg_sum, g_stage[k-1].res_q};
        end

        assign {seg_cout, seg_sum} = cla_segment(seg_a, seg_b, seg_cin);

        // Next state for this level: shift on advance, otherwise hold.
        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            res_d   = res_q;
            if (advance) begin
                valid_d = up_valid;
                carry_d = seg_cout;
                res_d   = res_new;
            end
        end

        // Level registers: valid bit, segment carry out, and the result bits done so far.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                res_q   <= res_d;
            end
        end

        // Operand bits for the segments that are still ahead ride along in skew registers.
        if (k < STAGES - 1) begin : g_skew
            localparam int unsigned SkW = WIDTH - (k + 1) * SEG;
            logic [SkW-1:0] a_up;
            logic [SkW-1:0] b_up;
            logic [SkW-1:0] a_d;
            logic [SkW-1:0] a_q;
            logic [SkW-1:0] b_d;
            logic [SkW-1:0] b_q;

            if (k == 0) begin : g_up
                assign a_up = a[WIDTH-1:SEG];
                assign b_up = b_eff[WIDTH-1:SEG];
            end else begin : g_up
                assign a_up = g_stage[k-1].g_skew.a_q[SkW+SEG-1:SEG];
                assign b_up = g_stage[k-1].g_skew.b_q[SkW+SEG-1:SEG];
            end

            // Skew next state: take the upper operand bits on advance, otherwise hold.
            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (advance) begin
                    a_d = a_up;
                    b_d = b_up;
                end
            end

            // Skew registers for the upper operand bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // The final level also registers overflow. Carry into the MSB is recovered as a^b'^s.
        if (k == STAGES - 1) begin : g_out
            logic ovf_d;
            logic ovf_q;

            // Overflow next state: carry into the MSB XOR carry out, updated on advance.
            always_comb begin
                ovf_d = ovf_q;
                if (advance) begin
                    ovf_d = seg_cout ^ seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_sum[SEG-1];
                end
            end

            // Overflow register, held during a stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end

`ifdef CLA_FLAGS_EN
        logic up_zero;
        logic zero_d;
        logic zero_q;

        if (k == 0) begin : g_zsrc
            assign up_zero = 1'b1;
        end else begin : g_zsrc
            assign up_zero = g_stage[k-1].zero_q;
        end

        // Zero flag is built one segment at a time, so no level reduces the full width.
        always_comb begin
            zero_d = zero_q;
            if (advance) begin
                zero_d = up_zero & ~|seg_sum;
            end
        end

        // Partial zero flag register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zero_q <= 1'b0;
            end else begin
                zero_q <= zero_d;
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].res_q;
    assign c_out     = g_stage[STAGES-1].carry_q;
    assign overflow  = g_stage[STAGES-1].g_out.ovf_q;

`ifdef CLA_FLAGS_EN
    assign zero     = g_stage[STAGES-1].zero_q;
    assign negative = sum[WIDTH-1];
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for two configurations,
// WIDTH=16/STAGES=2 and WIDTH=32/STAGES=4.
// Expected results are pushed to a queue at each accept and compared when the beat emerges.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        out_ready;
    logic        cin_in;
    logic        sub_in;
    logic        iv16;
    logic        iv32;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;
    logic        ir32, ov32, co32, of32;
    logic [31:0] s32;
`ifdef CLA_FLAGS_EN
    logic        z16, n16, z32, n32;
`endif

    pipelined_cla_adder #(.WIDTH(16), .STAGES(2), .GROUP(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a_in[15:0]),
        .b         (b_in[15:0]),
        .c_in      (cin_in),
        .sub       (sub_in),
        .out_valid (ov16),
        .out_ready (out_ready),
        .sum       (s16),
        .c_out     (co16),
`ifdef CLA_FLAGS_EN
        .zero      (z16),
        .negative  (n16),
`endif
        .overflow  (of16)
    );

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4), .GROUP(4)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .a         (a_in),
        .b         (b_in),
        .c_in      (cin_in),
        .sub       (sub_in),
        .out_valid (ov32),
        .out_ready (out_ready),
        .sum       (s32),
        .c_out     (co32),
`ifdef CLA_FLAGS_EN
        .zero      (z32),
        .negative  (n32),
`endif
        .overflow  (of32)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: plain wide addition; overflow taken from the operand and result signs.
    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic s, input int acc, input bit lat);
        exp_t        r;
        logic [32:0] full;
        logic [31:0] mask;
        logic [31:0] xm;
        logic [31:0] ym;
        mask   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        xm     = x & mask;
        ym     = (s ? ~y : y) & mask;
        full   = {1'b0, xm} + {1'b0, ym} + {32'd0, (s ? 1'b1 : ci)};
        r.sum  = full[31:0] & mask;
        r.cout = full[w];
        r.ovf  = (xm[w-1] == ym[w-1]) && (r.sum[w-1] != xm[w-1]);
        r.zero = (r.sum == 32'd0);
        r.neg  = r.sum[w-1];
        r.acc  = acc;
        r.lat  = lat;
        return r;
    endfunction

    // Output monitor, 16-bit DUT: compare each output sample with the head of the queue.
    always begin : mon16
        exp_t e;
        @(negedge clk);
        #3;
        if (rst_n && ov16) begin
            if (q16.size() == 0) begin
                check_eq("spurious16", 64'(ov16), 64'd0);
            end else begin
                e = q16[0];
                check_eq("sum16", 64'(s16), 64'(e.sum));
                check_eq("cout16", 64'(co16), 64'(e.cout));
                check_eq("ovf16", 64'(of16), 64'(e.ovf));
`ifdef CLA_FLAGS_EN
                check_eq("zero16", 64'(z16), 64'(e.zero));
                check_eq("neg16", 64'(n16), 64'(e.neg));
`endif
                if (!out_ready) begin
                    check_eq("in_ready_stall16", 64'(ir16), 64'd0);
                end else begin
                    if (e.lat) check_eq("latency16", 64'(cyc - e.acc), 64'd2);
                    void'(q16.pop_front());
                end
            end
        end
    end

    // Output monitor, 32-bit DUT.
    always begin : mon32
        exp_t e;
        @(negedge clk);
        #3;
        if (rst_n && ov32) begin
            if (q32.size() == 0) begin
                check_eq("spurious32", 64'(ov32), 64'd0);
            end else begin
                e = q32[0];
                check_eq("sum32", 64'(s32), 64'(e.sum));
                check_eq("cout32", 64'(co32), 64'(e.cout));
                check_eq("ovf32", 64'(of32), 64'(e.ovf));
`ifdef CLA_FLAGS_EN
                check_eq("zero32", 64'(z32), 64'(e.zero));
                check_eq("neg32", 64'(n32), 64'(e.neg));
`endif
                if (!out_ready) begin
                    check_eq("in_ready_stall32", 64'(ir32), 64'd0);
                end else begin
                    if (e.lat) check_eq("latency32", 64'(cyc - e.acc), 64'd4);
                    void'(q32.pop_front());
                end
            end
        end
    end

    // Offer one beat starting at a negedge; retry until accepted. Returns at a negedge.
    task automatic send(input bit sel, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s, input bit lat);
        bit   done = 1'b0;
        int   tries = 0;
        logic rdy;
        int   acc;
        a_in   = x;
        b_in   = y;
        cin_in = ci;
        sub_in = s;
        if (sel) iv32 = 1'b1;
        else     iv16 = 1'b1;
        while (!done) begin
            #4;
            rdy = sel ? ir32 : ir16;
            acc = cyc;
            @(posedge clk);
            if (rdy) begin
                if (sel) q32.push_back(model(32, x, y, ci, s, acc, lat));
                else     q16.push_back(model(16, x, y, ci, s, acc, lat));
                done = 1'b1;
            end else if (tries > 100) begin
                check_eq("accept_timeout", 64'(tries), 64'd0);
                done = 1'b1;
            end
            tries++;
            @(negedge clk);
        end
        iv16 = 1'b0;
        iv32 = 1'b0;
        // Scribble the operands: an accepted beat must not depend on them any more.
        a_in   = $urandom;
        b_in   = $urandom;
        cin_in = 1'($urandom_range(0, 1));
        sub_in = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input bit sel, input string tag);
        repeat (10) @(negedge clk);
        check_eq(tag, 64'(sel ? q32.size() : q16.size()), 64'd0);
    endtask

    task automatic run_suite(input bit sel);
        logic [31:0] da[5];
        logic [31:0] db[5];
        logic        dc[5];
        logic        ds[5];
        if (sel) da = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
        else     da = '{32'h0000_00FF, 32'h0000_FFFF, 32'h0000_7FFF, 32'h0000_0005, 32'h0000_8000};
        db = '{32'h1, 32'h0, 32'h1, 32'h7, 32'h1};
        dc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ds = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Directed cases, then 20 random back-to-back beats, all with exact latency checks.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(sel, da[i], db[i], dc[i], ds[i], 1'b1);
        for (int i = 0; i < 20; i++) begin
            send(sel, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b1);
        end
        drain(sel, "drain_b2b");

        // Backpressure: out_ready held low for 5 cycles while beats keep arriving.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(sel, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                end
            end
            begin
                repeat (3) @(negedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(negedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(sel, "drain_stall");

        // Random bubbles on the input and random backpressure on the output.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(sel, $urandom, $urandom, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b0);
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                end
            end
            begin
                repeat (60) begin
                    @(negedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain(sel, "drain_random");

        // Asynchronous reset with two beats in flight.
        send(sel, 32'h1357_9BDF, 32'h0246_8ACE, 1'b0, 1'b0, 1'b1);
        send(sel, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", 64'(sel ? ov32 : ov16), 64'd0);
        check_eq("rst_async_sum", sel ? 64'(s32) : 64'(s16), 64'd0);
        if (sel) q32.delete();
        else     q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(sel, 32'h0000_12FF, 32'h0000_0F01, 1'b1, 1'b0, 1'b1);
        drain(sel, "drain_after_rst");
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        iv16      = 1'b0;
        iv32      = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;
        sub_in    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid16", 64'(ov16), 64'd0);
        check_eq("rst_sum16", 64'(s16), 64'd0);
        check_eq("rst_cout16", 64'(co16), 64'd0);
        check_eq("rst_ovf16", 64'(of16), 64'd0);
        check_eq("rst_valid32", 64'(ov32), 64'd0);
        check_eq("rst_sum32", 64'(s32), 64'd0);
        check_eq("rst_cout32", 64'(co32), 64'd0);
        check_eq("rst_ovf32", 64'(of32), 64'd0);
        check_eq("rst_in_ready16", 64'(ir16), 64'd1);
`ifdef CLA_FLAGS_EN
        check_eq("rst_zero16", 64'(z16), 64'd0);
        check_eq("rst_neg16", 64'(n16), 64'd0);
        check_eq("rst_zero32", 64'(z32), 64'd0);
        check_eq("rst_neg32", 64'(n32), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        run_suite(1'b0);
        run_suite(1'b1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
